// File: rtl/alu_operand_buffer.sv
// Two-entry in-order operand buffer in front of the ALU: holds {A, B, opcode}
// sets, flags opcodes the ALU does not define, and counts issued entries.
module alu_operand_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALUOp,
    output logic        out_illegal,
    output logic [31:0] issued_cnt
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } entry_t;

    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [31:0] issued_q, issued_d;
    logic        push, pop;
    entry_t      in_entry;

    assign in_entry  = '{a: in_a, b: in_b, op: in_op};
    assign in_ready  = (count_q != 2'd2) & ~flush;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    // flush wins over a coincident pop, so such a pop is never counted.
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        issued_d = issued_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) head_d = tail_q;
            if (push) begin
                // The new entry becomes the head when the buffer is, or is about to be, empty.
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) head_d = in_entry;
                else                                              tail_d = in_entry;
            end
            count_d  = count_q + 2'(push) - 2'(pop);
            issued_d = issued_q + 32'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the entry storage is reset too, so no stale operands survive a reset.
        if (reset) begin
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            issued_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates on the same edge.
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            issued_q <= issued_d;
        end
    end

    // Stale entry contents are masked so an empty buffer drives zeros to the ALU.
    assign A           = out_valid ? head_q.a  : 32'd0;
    assign B           = out_valid ? head_q.b  : 32'd0;
    assign ALUOp       = out_valid ? head_q.op : 3'd0;
    assign out_illegal = out_valid & (ALUOp == 3'b110 || ALUOp == 3'b111);
    assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_alu_operand_buffer.sv
// Directed bench for alu_operand_buffer: latency, backpressure, push+pop,
// flush priority, illegal opcodes and asynchronous reset.
module tb_alu_operand_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic        out_illegal;
    logic [31:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    alu_operand_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (A),
        .B           (B),
        .ALUOp       (ALUOp),
        .out_illegal (out_illegal),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic ordy, input logic fl);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_A", A, 32'd0);
        check("rst_ALUOp", 32'(ALUOp), 32'd0);
        check("rst_issued", issued_cnt, 32'd0);
        flush = 1'b1;
        #1;
        check("rst_flush_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b0;
        #1;
        reset = 1'b0;

        // Basic latency: no bypass, visible after one edge.
        drive(1'b1, 32'd5, 32'd3, 3'b000, 1'b0, 1'b0);
        #1;
        check("lat_no_bypass", 32'(out_valid), 32'd0);
        tick();
        idle();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_A", A, 32'd5);
        check("lat_B", B, 32'd3);
        check("lat_op", 32'(ALUOp), 32'd0);
        check("lat_issued", issued_cnt, 32'd0);
        check("lat_illegal", 32'(out_illegal), 32'd0);
        out_ready = 1'b1;
        tick();
        idle();
        check("lat_pop_valid", 32'(out_valid), 32'd0);
        check("lat_pop_issued", issued_cnt, 32'd1);
        check("empty_A_zero", A, 32'd0);

        // Fill and backpressure.
        drive(1'b1, 32'h11, 32'h111, 3'b001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 32'h222, 3'b010, 1'b0, 1'b0);
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h99, 32'h999, 3'b011, 1'b0, 1'b0);
        tick();
        check("hold_A", A, 32'h11);
        check("hold_B", B, 32'h111);
        check("hold_op", 32'(ALUOp), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
        tick();
        check("pop1_A", A, 32'h22);
        check("pop1_op", 32'(ALUOp), 32'd2);
        check("pop1_in_ready", 32'(in_ready), 32'd1);
        check("pop1_issued", issued_cnt, 32'd2);
        tick();
        idle();
        check("pop2_valid", 32'(out_valid), 32'd0);
        check("pop2_issued", issued_cnt, 32'd3);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 32'h11, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h33, 32'h3, 3'b100, 1'b1, 1'b0);
        tick();
        idle();
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_A", A, 32'h33);
        check("pp_op", 32'(ALUOp), 32'd4);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        check("pp_issued", issued_cnt, 32'd4);
        out_ready = 1'b1;
        tick();
        idle();
        check("pp_drain_valid", 32'(out_valid), 32'd0);
        check("pp_drain_issued", issued_cnt, 32'd5);

        // Flush priority over push and pop.
        drive(1'b1, 32'h44, 32'h4, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h55, 32'h5, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h66, 32'h6, 3'b000, 1'b1, 1'b1);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        idle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_issued", issued_cnt, 32'd5);
        check("flush_A", A, 32'd0);
        tick();
        check("flush_discard", 32'(out_valid), 32'd0);

        // Illegal opcodes are flagged but buffered normally.
        drive(1'b1, 32'h7, 32'h7, 3'b110, 1'b0, 1'b0);
        tick();
        idle();
        check("ill110_flag", 32'(out_illegal), 32'd1);
        check("ill110_op", 32'(ALUOp), 32'd6);
        drive(1'b1, 32'h8, 32'h8, 3'b101, 1'b1, 1'b0);
        tick();
        idle();
        check("ok101_flag", 32'(out_illegal), 32'd0);
        check("ok101_A", A, 32'h8);
        check("ill_pop_issued", issued_cnt, 32'd6);
        drive(1'b1, 32'h9, 32'h9, 3'b111, 1'b1, 1'b0);
        tick();
        idle();
        check("ill111_flag", 32'(out_illegal), 32'd1);
        out_ready = 1'b1;
        tick();
        idle();
        check("ill_empty_flag", 32'(out_illegal), 32'd0);
        check("ill_drain_issued", issued_cnt, 32'd8);

        // Asynchronous reset between edges at count 2.
        drive(1'b1, 32'h77, 32'h7, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h88, 32'h8, 3'b000, 1'b0, 1'b0);
        tick();
        idle();
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_issued", issued_cnt, 32'd0);
        check("arst_A", A, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'haa, 32'hbb, 3'b111, 1'b1, 1'b0);
        tick();
        check("arst_push_ignored", 32'(out_valid), 32'd0);
        check("arst_illegal", 32'(out_illegal), 32'd0);
        idle();
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_issued", issued_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
